pc_unit: RTL and testbench

- Parametrised program-counter unit for the RV32-style fetch stage.
- Generates the instruction pointer, holds fetch while a control-transfer instruction resolves, then applies the resolved target.
- Generalises the single-cycle-stall PC:
  - configurable width, reset vector and resolve latency
  - absolute JALR targets
  - fetch back-pressure
  - external redirect (trap/flush)
  - misaligned-target detection

---
 rtl/pc_unit_if.sv | 47 ++++
 rtl/pc_unit.sv | 133 +++++++++++++
 tb/tb_pc_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// pc_unit_if
// Groups the fetch-stage handshake and resolution signals of the program
// counter unit so they travel as a single bundle.
//
// Signals:
//   op             opcode of the instruction at IP (valid when fetch_rdy=1)
//   fetch_rdy      fetch accepted the current IP; 0 holds IP while running
//   b_taken        branch outcome, sampled on the resolve cycle
//   up_amt         signed offset (branch/JAL imm or JALR imm)
//   jalr_base      rs1 value for JALR
//   redirect_valid external trap/flush request
//   redirect_pc    redirect target
//   IP             current instruction pointer (registered)
//   PC_def         IP+4, combinational, wraps
//   stall_o        high while a control transfer is resolving
//   misalign_o     one-cycle pulse when a misaligned target is trapped
//
// Modports:
//   master  drives requests (fetch/decode side), observes the PC
//   slave   the PC unit itself
interface pc_unit_if #(
    parameter int XLEN = 32
);
    logic [6:0]      op;
    logic            fetch_rdy;
    logic            b_taken;
    logic [XLEN-1:0] up_amt;
    logic [XLEN-1:0] jalr_base;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] IP;
    logic [XLEN-1:0] PC_def;
    logic            stall_o;
    logic            misalign_o;

    modport master (
        output op, fetch_rdy, b_taken, up_amt, jalr_base,
               redirect_valid, redirect_pc,
        input  IP, PC_def, stall_o, misalign_o
    );

    modport slave (
        input  op, fetch_rdy, b_taken, up_amt, jalr_base,
               redirect_valid, redirect_pc,
        output IP, PC_def, stall_o, misalign_o
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit
// Program-counter unit for an RV32-style fetch stage. Advances the
// instruction pointer by 4 per accepted fetch, freezes while a control
// transfer (JAL/JALR/BRANCH) resolves over RESOLVE_CYC cycles, then loads
// the resolved target. Misaligned taken targets are replaced by
// TRAP_VECTOR with a one-cycle misalign_o pulse. An external redirect
// overrides everything except reset.
//
// Ports:
//   CLK    rising-edge clock
//   RESET  asynchronous active-low reset
//   bus    pc_unit_if slave modport (see interface header for signals)
//
// Parameters:
//   XLEN         address width
//   RESET_VECTOR IP after reset
//   TRAP_VECTOR  IP loaded on a misaligned taken target
//   RESOLVE_CYC  cycles spent stalled per control transfer (1..7)
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
    parameter int              RESOLVE_CYC  = 1
) (
    input  logic      CLK,
    input  logic      RESET,
    pc_unit_if.slave  bus
);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // The counter preload is RESOLVE_CYC-1 so that the cnt==0 cycle is the
    // last of exactly RESOLVE_CYC stalled cycles.
    localparam logic [2:0] CNT_INIT = 3'(RESOLVE_CYC - 1);

    typedef enum logic {
        S_RUN,
        S_WAIT
    } state_t;

    state_t          state;
    logic [2:0]      cnt;
    logic [6:0]      op_q;
    logic [XLEN-1:0] ip_q;
    logic            stall_q;
    logic            misalign_q;

    logic [XLEN-1:0] pc_def;
    logic            is_control;
    logic            taken;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;

    assign pc_def         = ip_q + XLEN'(4);
    assign bus.IP         = ip_q;
    assign bus.PC_def     = pc_def;
    assign bus.stall_o    = stall_q;
    assign bus.misalign_o = misalign_q;

    // Decode the fetched opcode and the resolved target. The target uses
    // the held IP, which is still the address of the control instruction
    // on the resolve cycle. JALR clears bit 0 before the alignment check.
    always_comb begin
        is_control = (bus.op == OP_JAL) || (bus.op == OP_JALR) ||
                     (bus.op == OP_BRANCH);
        taken      = (op_q == OP_JAL) || (op_q == OP_JALR) ||
                     ((op_q == OP_BRANCH) && bus.b_taken);
        jalr_sum   = bus.jalr_base + bus.up_amt;
        target     = ip_q + bus.up_amt;
        if (op_q == OP_JALR) begin
            target = jalr_sum & ~XLEN'(1);
        end
    end

    // Single state machine: reset, then redirect, then RUN/WAIT sequencing.
    // stall_o and misalign_o are registered alongside the state so they
    // line up with the IP they describe.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_RUN;
            cnt        <= '0;
            op_q       <= '0;
            ip_q       <= RESET_VECTOR;
            stall_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            // Discards any pending resolution; redirect_pc is trusted as-is.
            state      <= S_RUN;
            cnt        <= '0;
            ip_q       <= bus.redirect_pc;
            stall_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state)
                S_RUN: begin
                    if (bus.fetch_rdy) begin
                        if (is_control) begin
                            op_q    <= bus.op;
                            cnt     <= CNT_INIT;
                            state   <= S_WAIT;
                            stall_q <= 1'b1;
                        end else begin
                            ip_q <= pc_def;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        state   <= S_RUN;
                        stall_q <= 1'b0;
                        if (!taken) begin
                            ip_q <= pc_def;
                        end else if (target[1:0] != 2'b00) begin
                            ip_q       <= TRAP_VECTOR;
                            misalign_q <= 1'b1;
                        end else begin
                            ip_q <= target;
                        end
                    end
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit
// Scoreboard bench for pc_unit with RESOLVE_CYC=2. The driver applies one
// directed vector per clock and pushes the hand-computed IP/stall/misalign
// expected after that edge; an independent monitor pops and compares on
// every falling edge.
module tb_pc_unit;

    localparam int          XLEN   = 32;
    localparam logic [31:0] RV     = 32'h0;
    localparam logic [31:0] TV     = 32'h100;
    localparam logic [6:0]  NOP    = 7'b0010011;
    localparam logic [6:0]  JAL    = 7'b1101111;
    localparam logic [6:0]  JALR   = 7'b1100111;
    localparam logic [6:0]  BRANCH = 7'b1100011;

    typedef struct {
        string       name;
        logic [31:0] ip;
        logic        stall;
        logic        mis;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    pc_unit_if #(.XLEN(XLEN)) bus ();

    pc_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .RESOLVE_CYC  (2)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then record what must be visible after
    // the edge that consumes them.
    task automatic applyStimulus(input string name, input logic [6:0] o,
                                 input logic rdy, input logic bt,
                                 input logic [31:0] amt, input logic [31:0] base,
                                 input logic rv, input logic [31:0] rpc,
                                 input logic [31:0] eip, input logic est,
                                 input logic emis);
        exp_t e;
        bus.op             = o;
        bus.fetch_rdy      = rdy;
        bus.b_taken        = bt;
        bus.up_amt         = amt;
        bus.jalr_base      = base;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        @(posedge clk);
        e.name  = name;
        e.ip    = eip;
        e.stall = est;
        e.mis   = emis;
        sb.push_back(e);
        #1;
    endtask

    task automatic redirectTo(input logic [31:0] pc);
        applyStimulus("redir", NOP, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, pc, pc, 1'b0, 1'b0);
    endtask

    task automatic nop(input logic [31:0] eip);
        applyStimulus("seq", NOP, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, eip, 1'b0, 1'b0);
    endtask

    // Monitor: compares every recorded expectation against the DUT.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput({e.name, ".ip"}, bus.IP, e.ip);
            checkOutput({e.name, ".pc_def"}, bus.PC_def, e.ip + 32'd4);
            checkOutput({e.name, ".stall"}, 32'(bus.stall_o), 32'(e.stall));
            checkOutput({e.name, ".misalign"}, 32'(bus.misalign_o), 32'(e.mis));
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.op = NOP;
        bus.fetch_rdy = 1'b0;
        bus.b_taken = 1'b0;
        bus.up_amt = '0;
        bus.jalr_base = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        #2;
        $display("[TB] reset state");
        checkOutput("reset.ip", bus.IP, RV);
        checkOutput("reset.stall", 32'(bus.stall_o), 32'd0);
        checkOutput("reset.misalign", 32'(bus.misalign_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sequential fetch, then back-pressure at 0x8 with a control op
        // present that must be ignored.
        nop(32'h4);
        nop(32'h8);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("hold", JAL, 1'b0, 1'b1, 32'h40, 32'h0, 1'b0, 32'h0,
                          32'h8, 1'b0, 1'b0);
        end
        nop(32'hC);
        nop(32'h10);

        // Branch taken backwards by 8; filler cycle inputs are don't-care.
        redirectTo(32'h20);
        applyStimulus("br_t", BRANCH, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h20, 1'b1, 1'b0);
        applyStimulus("br_t", NOP, 1'b0, 1'b0, 32'h1234, 32'h0, 1'b0, 32'h0, 32'h20, 1'b1, 1'b0);
        applyStimulus("br_t", NOP, 1'b0, 1'b1, 32'hFFFFFFF8, 32'h0, 1'b0, 32'h0, 32'h18, 1'b0, 1'b0);

        // Branch not taken falls through.
        redirectTo(32'h20);
        applyStimulus("br_n", BRANCH, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h20, 1'b1, 1'b0);
        applyStimulus("br_n", NOP, 1'b1, 1'b1, 32'hFFFFFFF8, 32'h0, 1'b0, 32'h0, 32'h20, 1'b1, 1'b0);
        applyStimulus("br_n", NOP, 1'b1, 1'b0, 32'hFFFFFFF8, 32'h0, 1'b0, 32'h0, 32'h24, 1'b0, 1'b0);

        // JALR: 0x1001 + 4 = 0x1005, bit0 cleared -> 0x1004.
        redirectTo(32'h40);
        applyStimulus("jalr", JALR, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h40, 1'b1, 1'b0);
        applyStimulus("jalr", NOP, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h40, 1'b1, 1'b0);
        applyStimulus("jalr", NOP, 1'b0, 1'b0, 32'h4, 32'h1001, 1'b0, 32'h0, 32'h1004, 1'b0, 1'b0);

        // JAL to 0x56 is misaligned -> trap vector with one-cycle pulse.
        redirectTo(32'h50);
        applyStimulus("jal_mis", JAL, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h50, 1'b1, 1'b0);
        applyStimulus("jal_mis", NOP, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h50, 1'b1, 1'b0);
        applyStimulus("jal_mis", NOP, 1'b0, 1'b0, 32'h6, 32'h0, 1'b0, 32'h0, TV, 1'b0, 1'b1);
        nop(TV + 32'h4);

        // JALR to 0x1002: bit1 survives the bit0 clear -> trap.
        redirectTo(32'h60);
        applyStimulus("jalr_mis", JALR, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h60, 1'b1, 1'b0);
        applyStimulus("jalr_mis", NOP, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h60, 1'b1, 1'b0);
        applyStimulus("jalr_mis", NOP, 1'b0, 1'b0, 32'h1, 32'h1001, 1'b0, 32'h0, TV, 1'b0, 1'b1);

        // Wrap-around of the sequential increment.
        redirectTo(32'hFFFFFFFC);
        nop(32'h0);

        // Redirect mid-WAIT discards the branch; the next fetch is normal.
        redirectTo(32'h70);
        applyStimulus("rd_wait", BRANCH, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h70, 1'b1, 1'b0);
        applyStimulus("rd_wait", NOP, 1'b0, 1'b1, 32'hFFFFFFF8, 32'h0, 1'b1, 32'h200, 32'h200, 1'b0, 1'b0);
        nop(32'h204);
        nop(32'h208);

        // Redirect target is not alignment-checked.
        applyStimulus("rd_odd", NOP, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h202, 32'h202, 1'b0, 1'b0);

        // Asynchronous reset while stalled.
        redirectTo(32'h30);
        applyStimulus("areset", BRANCH, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h30, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("areset.ip", bus.IP, RV);
        checkOutput("areset.stall", 32'(bus.stall_o), 32'd0);
        @(negedge clk);
        checkOutput("areset.held_ip", bus.IP, RV);
        checkOutput("scoreboard.drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
